// File: rtl/cla_pkg.sv
// Shared constants and the pipeline token carried between borrow-lookahead stages.
package cla_pkg;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 8;
  localparam int STAGES = WIDTH / SLICE;

  // One in-flight subtraction. Operands are kept shifted so that the slice a
  // stage must resolve always sits in bits [SLICE-1:0]; d fills from the bottom.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow;
    logic             a_sign;
    logic             b_sign;
  } tok_t;

endpackage

// File: rtl/cla_sub_slice8.sv
// Combinational 8-bit borrow-lookahead slice: d = a - b - bi, bo = borrow out.
module cla_sub_slice8
  import cla_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bi,
  output logic [SLICE-1:0] d,
  output logic             bo
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   br;
  logic             all_p;
  logic             term;
  logic             sum;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Each borrow is expanded to sum-of-products over g/p and bi, no ripple.
  always_comb begin
    br    = '0;
    all_p = 1'b1;
    term  = 1'b0;
    sum   = 1'b0;
    for (int i = 0; i <= SLICE; i++) begin
      all_p = 1'b1;
      for (int j = 0; j < i; j++) all_p = all_p & p[j];
      sum = bi & all_p;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        sum = sum | term;
      end
      br[i] = sum;
    end
  end

  assign d  = a ^ b ^ br[SLICE-1:0];
  assign bo = br[SLICE];

endmodule

// File: rtl/cla_sub_pipe64.sv
// Pipelined 64-bit borrow-lookahead subtractor: D = A - B - Bin, one 8-bit
// slice resolved per stage, result plus flags registered at the output.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds its payload while valid & !ready; the consumer side
// (out_valid/D/Bout/zero/ovf) is held stable here while out_valid & !out_ready.
// The pipeline uses a global stall: every stage holds when the output is full
// and not being taken.
module cla_sub_pipe64
  import cla_pkg::tok_t;
#(
  parameter int WIDTH = cla_pkg::WIDTH,
  parameter int SLICE = cla_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;

  // tok_q[k] is the token waiting for stage k to resolve slice k.
  tok_t             tok_q     [STAGES];
  tok_t             tok_d     [STAGES];
  tok_t             stage_out [STAGES];
  logic [SLICE-1:0] sl_d      [STAGES];
  logic             sl_bo     [STAGES];

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;
  tok_t             fin;
  logic             zero_d;
  logic             ovf_d;
  logic             unused_tail;

  assign advance  = !out_valid_q | out_ready;
  assign in_ready = advance & !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla_sub_slice8 u_slice (
      .a  (tok_q[k].a[SLICE-1:0]),
      .b  (tok_q[k].b[SLICE-1:0]),
      .bi (tok_q[k].borrow),
      .d  (sl_d[k]),
      .bo (sl_bo[k])
    );
  end

  // Build each stage's outgoing token and the capture of a new operand pair.
  always_comb begin
    tok_d[0].valid  = in_valid & in_ready;
    tok_d[0].d      = '0;
    tok_d[0].a      = A;
    tok_d[0].b      = B;
    tok_d[0].borrow = Bin;
    tok_d[0].a_sign = A[WIDTH-1];
    tok_d[0].b_sign = B[WIDTH-1];
    for (int k = 0; k < STAGES; k++) begin
      stage_out[k]                    = tok_q[k];
      stage_out[k].d[k*SLICE +: SLICE] = sl_d[k];
      stage_out[k].a                  = tok_q[k].a >> SLICE;
      stage_out[k].b                  = tok_q[k].b >> SLICE;
      stage_out[k].borrow             = sl_bo[k];
    end
    for (int k = 1; k < STAGES; k++) tok_d[k] = stage_out[k-1];
  end

  assign fin         = stage_out[STAGES-1];
  assign zero_d      = (fin.d == '0);
  assign ovf_d       = (fin.a_sign ^ fin.b_sign) & (fin.a_sign ^ fin.d[WIDTH-1]);
  // Operand bits are fully consumed once the last slice is resolved.
  assign unused_tail = ^{fin.a, fin.b};

  // Stage registers and output register advance together or hold together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) tok_q[k] <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) tok_q[k] <= tok_d[k];
      out_valid_q <= fin.valid;
      d_q         <= fin.d;
      bout_q      <= fin.borrow;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe64.sv
// Self-checking bench for cla_sub_pipe64 against an arithmetic reference model.
module tb_cla_sub_pipe64;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         zero;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // expected {D, Bout, zero, ovf}
  logic [W+2:0] exp_q[$];

  cla_sub_pipe64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    logic [W:0]          u;
    logic signed [W+1:0] s;
    logic                r_zero;
    logic                r_ovf;
    u      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    s      = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b}) - $signed({{(W+1){1'b0}}, bin});
    r_zero = (u[W-1:0] == '0);
    // signed result outside the W-bit two's complement range
    r_ovf  = (s > $signed({3'b000, {(W-1){1'b1}}})) || (s < -$signed({3'b001, {(W-1){1'b0}}}));
    return {u[W-1:0], u[W], r_zero, r_ovf};
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_tests++; if ({D, Bout, zero, ovf} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", {D, Bout, zero, ovf}); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high: got %b exp 1", in_ready); end
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic bin, input logic [W-1:0] e_d, input logic e_bout,
                              input logic e_zero, input logic e_ovf);
    int lat;
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; Bin = bin; out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b exp 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; A = rand64(); B = rand64(); Bin = $urandom_range(0, 1);
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat = i;
    end
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL %s_latency: got %0d exp 8", name, lat); end
    n_tests++; if ({D, Bout, zero, ovf} !== {e_d, e_bout, e_zero, e_ovf}) begin
      n_fail++; $display("FAIL %s_result: got D=%h Bout=%b zero=%b ovf=%b exp D=%h Bout=%b zero=%b ovf=%b",
                         name, D, Bout, zero, ovf, e_d, e_bout, e_zero, e_ovf);
    end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_single: got out_valid=%b exp 0", name, out_valid); end
  endtask

  task automatic test_directed();
    run_directed("sub_5_3",   64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
    run_directed("sub_5_3_b", 64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
    run_directed("borrow_all", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_directed("borrow_in", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_directed("signed_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_directed("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    run_directed("zero", 64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] e;
    for (int c = 0; c < 115; c++) begin
      @(negedge clk);
      in_valid = (c < 100); A = rand64(); B = rand64(); Bin = $urandom_range(0, 1);
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== ((c >= 9) && (c <= 108))) begin
        n_fail++; $display("FAIL b2b_out_valid c=%0d: got %b exp %b", c, out_valid, (c >= 9) && (c <= 108));
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got D=%h exp no result", D);
        end else begin
          e = exp_q.pop_front();
          if ({D, Bout, zero, ovf} !== e) begin
            n_fail++; $display("FAIL b2b_data: got %h exp %h", {D, Bout, zero, ovf}, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sub(A, B, Bin));
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_lost: got %0d left exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_random_stall();
    logic [W+2:0] e;
    logic [W+2:0] held;
    logic         held_valid;
    held_valid = 1'b0;
    held       = '0;
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      in_valid  = (c < 260); A = rand64(); B = rand64(); Bin = $urandom_range(0, 1);
      out_ready = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      n_tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL stall_in_ready c=%0d: got %b exp %b", c, in_ready, !out_valid || out_ready);
      end
      if (held_valid) begin
        n_tests++;
        if (!out_valid || {D, Bout, zero, ovf} !== held) begin
          n_fail++; $display("FAIL stall_hold c=%0d: got v=%b %h exp v=1 %h", c, out_valid, {D, Bout, zero, ovf}, held);
        end
      end
      held_valid = out_valid && !out_ready;
      held       = {D, Bout, zero, ovf};
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: got D=%h exp no result", D);
        end else begin
          e = exp_q.pop_front();
          if ({D, Bout, zero, ovf} !== e) begin
            n_fail++; $display("FAIL stall_data: got %h exp %h", {D, Bout, zero, ovf}, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sub(A, B, Bin));
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_lost: got %0d left exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_flush();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W+2:0] e;
    int           lat;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; A = rand64(); B = rand64(); Bin = $urandom_range(0, 1); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_rst: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    n_tests++; if ({out_valid, D, Bout, zero, ovf} !== '0) begin
      n_fail++; $display("FAIL flush_outputs: got v=%b %h exp 0", out_valid, {D, Bout, zero, ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_after: got %b exp 1", in_ready); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost c=%0d: got %b exp 0", c, out_valid); end
    end
    a = rand64(); b = rand64(); bin = $urandom_range(0, 1);
    e = ref_sub(a, b, bin);
    in_valid = 1'b1; A = a; B = b; Bin = bin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat = i;
    end
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL flush_new_latency: got %0d exp 8", lat); end
    n_tests++; if ({D, Bout, zero, ovf} !== e) begin
      n_fail++; $display("FAIL flush_new_data: got %h exp %h", {D, Bout, zero, ovf}, e);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stall();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
